jhash_packer: RTL and testbench
===============================

Name: jhash_packer

Overview:
- Upstream feeder for the jhash core.
- Accepts a 32-bit word stream with a valid/ready handshake and packs it into triples on stream_data0/1/2.
- Presents each triple with stream_valid/stream_ack and spaces groups so the core finishes its 6-round mix before the next beat.
- Signals the final (possibly partial) group with stream_done/stream_left, then waits for hash_done. One message per reset.

Parameters:
HOLDOFF  7  cycles after stream_ack during which stream_valid/stream_done are held low (1 load cycle + 6 mix rounds)
CNT_W  16  width of word_cnt

Ports:
clk  input  1  clock, all state on posedge
rst  input  1  asynchronous, active-high reset
in_data  input  32  message word
in_valid  input  1  in_data valid
in_last  input  1  qualifies in_valid: this word is the last of the message
in_empty  input  1  one-cycle strobe: zero-length message; honoured only in S_FILL with word_cnt==0
in_ready  output  1  word accepted when in_valid&in_ready
stream_data0  output  32  group word 0
stream_data1  output  32  group word 1
stream_data2  output  32  group word 2
stream_valid  output  1  group presented to core
stream_done  output  1  final group
stream_left  output  2  words valid in final group (0..3); 0 when stream_done=0
stream_ack  input  1  core consumed a non-final group
hash_done  input  1  core reached its done state
word_cnt  output  CNT_W  words accepted this message, saturating at all-ones
pack_done  output  1  hash_done seen, message complete

Behaviour:
- Reset (async, immediate):
  - state=S_FILL; slot=0; all stream_* outputs 0; word_cnt=0; pack_done=0; holdoff counter=0.
- Outputs are registered except in_ready, which is combinational from state and slot.
- States:
  - S_FILL:
    - in_ready=1.
    - An accepted word is written to stream_data[slot]; slot increments.
    - Accepted word with in_last=1 and slot at 0/1/2 -> S_FINAL with left=1/2/3. A length that is a multiple of 3 words ends with left=3, never a trailing left=0 beat.
    - Accepted word with in_last=0 and slot==2 -> S_SEND.
    - in_empty with word_cnt==0 -> S_FINAL with left=0 and all data zero.
    - in_empty is ignored in all other cases.
  - S_SEND:
    - in_ready=0; stream_valid=1; stream_done=0.
    - Data is held stable until stream_ack.
    - On stream_ack: stream_valid=0 next cycle, slots and data cleared to 0, counter=HOLDOFF -> S_HOLD.
  - S_HOLD:
    - in_ready=0; all stream_* outputs low; counter decrements each cycle.
    - Leaves to S_FILL on the cycle the counter reaches 0. The first in_ready is exactly HOLDOFF+1 cycles after the ack cycle.
  - S_FINAL:
    - in_ready=0; stream_valid=1; stream_done=1; stream_left=left.
    - Unused data words are 0.
    - Held until hash_done=1 -> S_END.
    - stream_ack in S_FINAL is ignored.
  - S_END:
    - pack_done=1; stream_valid=0; stream_done=0; in_ready=0.
    - Exits only by rst.
- stream_done is never high before the final group. The hold-off guarantees the core has returned to its load state before stream_done rises.
- in_valid while in_ready=0: word not taken; the source must hold it.
- word_cnt increments on each accepted word and saturates.
- rst mid-message discards all partial data and returns to S_FILL immediately.

Optional Feature:
JHASH_PACK_SWAP_EN:
- Defined: every accepted word is byte-reversed before storage, i.e. {in_data[7:0],in_data[15:8],in_data[23:16],in_data[31:24]}, for big-endian sources.
- Undefined: words are stored unchanged.
- Handshakes and timing are identical in both builds.

Test Plan:
- 3 words 0x11111111, 0x22222222, 0x33333333, last on 3rd -> S_FINAL: stream_done=1, stream_left=3, data0..2 as sent; no stream_valid-only beat; pack_done 1 cycle after hash_done.
- 4 words 1,2,3,4 (last on 4th) -> SEND {1,2,3}; ack; stream_valid low and in_ready low for 7 cycles; then final {4,0,0}, left=1, word_cnt=4.
- in_empty strobe right after reset -> stream_valid=1, stream_done=1, left=0, data all 0.
- Core delays stream_ack 5 cycles in S_SEND while in_valid stays high -> data stable, in_ready=0, no word lost; the 4th word is accepted after hold-off.
- Assert rst during S_HOLD after 3 of 5 words -> all outputs 0 immediately; a following 2-word message yields a final group with left=2.
- JHASH_PACK_SWAP_EN defined: input 0xAABBCCDD, last -> stream_data0=0xDDCCBBAA, left=1.

Source files
------------

// File: rtl/jhash_packer_if.sv
// Word-stream and group-stream signals between a source, the packer and the jhash core.
// The packer uses the slave modport; the source/core side uses master.
interface jhash_packer_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_empty;
  logic             in_ready;
  logic [31:0]      stream_data0;
  logic [31:0]      stream_data1;
  logic [31:0]      stream_data2;
  logic             stream_valid;
  logic             stream_done;
  logic [1:0]       stream_left;
  logic             stream_ack;
  logic             hash_done;
  logic [CNT_W-1:0] word_cnt;
  logic             pack_done;

  modport master (
    output in_data, in_valid, in_last, in_empty, stream_ack, hash_done,
    input  in_ready, stream_data0, stream_data1, stream_data2,
           stream_valid, stream_done, stream_left, word_cnt, pack_done
  );

  modport slave (
    input  in_data, in_valid, in_last, in_empty, stream_ack, hash_done,
    output in_ready, stream_data0, stream_data1, stream_data2,
           stream_valid, stream_done, stream_left, word_cnt, pack_done
  );
endinterface

// File: rtl/jhash_packer.sv
// Packs a 32-bit word stream into triples for the jhash core, with hold-off between groups.
// Optional JHASH_PACK_SWAP_EN: byte-reverse every accepted word before storage.
module jhash_packer #(
  parameter int HOLDOFF = 7,
  parameter int CNT_W   = 16
) (
  input logic           clk,
  input logic           rst,
  jhash_packer_if.slave bus
);

  // state   | meaning
  // S_FILL  | accepting words into slots 0..2
  // S_SEND  | full non-final group presented, waiting for stream_ack
  // S_HOLD  | core loading and mixing; counter runs down to 0
  // S_FINAL | final group presented with stream_done, waiting for hash_done
  // S_END   | message complete, only rst leaves
  typedef enum logic [2:0] {S_FILL, S_SEND, S_HOLD, S_FINAL, S_END} state_t;

  localparam int HOLD_W = $clog2(HOLDOFF + 1);

  state_t           state, state_n;
  logic [1:0]       slot, slot_n;
  logic [31:0]      data0, data1, data2;
  logic [31:0]      data0_n, data1_n, data2_n;
  logic [1:0]       left, left_n;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_n;
  logic [CNT_W-1:0] word_cnt, word_cnt_n;
  logic             valid_q, done_q, pack_done_q;
  logic             valid_n, done_n, pack_done_n;
  logic [31:0]      word_in;
  logic             accept;

`ifdef JHASH_PACK_SWAP_EN
  assign word_in = {bus.in_data[7:0], bus.in_data[15:8], bus.in_data[23:16], bus.in_data[31:24]};
`else
  assign word_in = bus.in_data;
`endif

  assign accept = bus.in_valid && (state == S_FILL);

  always_comb begin
    state_n     = state;
    slot_n      = slot;
    data0_n     = data0;
    data1_n     = data1;
    data2_n     = data2;
    left_n      = left;
    hold_cnt_n  = hold_cnt;
    word_cnt_n  = word_cnt;
    unique case (state)
      S_FILL: begin
        // A zero-length message only makes sense before any word arrived.
        if (bus.in_empty && (word_cnt == '0)) begin
          state_n = S_FINAL;
          left_n  = 2'd0;
          data0_n = '0;
          data1_n = '0;
          data2_n = '0;
        end else if (accept) begin
          case (slot)
            2'd0:    data0_n = word_in;
            2'd1:    data1_n = word_in;
            default: data2_n = word_in;
          endcase
          slot_n     = slot + 2'd1;
          word_cnt_n = (&word_cnt) ? word_cnt : word_cnt + CNT_W'(1);
          if (bus.in_last) begin
            state_n = S_FINAL;
            left_n  = slot + 2'd1;
          end else if (slot == 2'd2) begin
            state_n = S_SEND;
          end
        end
      end
      S_SEND: begin
        if (bus.stream_ack) begin
          state_n    = S_HOLD;
          slot_n     = 2'd0;
          data0_n    = '0;
          data1_n    = '0;
          data2_n    = '0;
          hold_cnt_n = HOLD_W'(HOLDOFF);
        end
      end
      S_HOLD: begin
        hold_cnt_n = hold_cnt - HOLD_W'(1);
        if (hold_cnt <= HOLD_W'(1)) begin
          state_n    = S_FILL;
          hold_cnt_n = '0;
        end
      end
      S_FINAL: begin
        if (bus.hash_done) begin
          state_n = S_END;
          left_n  = 2'd0;
        end
      end
      S_END: begin
        state_n = S_END;
      end
      default: begin
        state_n = S_FILL;
      end
    endcase
    valid_n     = (state_n == S_SEND) || (state_n == S_FINAL);
    done_n      = (state_n == S_FINAL);
    pack_done_n = (state_n == S_END);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_FILL;
      slot        <= 2'd0;
      data0       <= '0;
      data1       <= '0;
      data2       <= '0;
      left        <= 2'd0;
      hold_cnt    <= '0;
      word_cnt    <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      pack_done_q <= 1'b0;
    end else begin
      state       <= state_n;
      slot        <= slot_n;
      data0       <= data0_n;
      data1       <= data1_n;
      data2       <= data2_n;
      left        <= left_n;
      hold_cnt    <= hold_cnt_n;
      word_cnt    <= word_cnt_n;
      valid_q     <= valid_n;
      done_q      <= done_n;
      pack_done_q <= pack_done_n;
    end
  end

  assign bus.in_ready     = (state == S_FILL);
  assign bus.stream_data0 = data0;
  assign bus.stream_data1 = data1;
  assign bus.stream_data2 = data2;
  assign bus.stream_valid = valid_q;
  assign bus.stream_done  = done_q;
  assign bus.stream_left  = left;
  assign bus.word_cnt     = word_cnt;
  assign bus.pack_done    = pack_done_q;

endmodule

// File: tb/tb_jhash_packer.sv
// Scoreboard bench for jhash_packer: a message model predicts groups, a monitor checks them.
module tb_jhash_packer;
  localparam int CNT_W   = 16;
  localparam int HOLDOFF = 7;

  typedef logic [31:0] wq_t[$];
  typedef struct {
    logic [31:0] d0, d1, d2;
    logic        done;
    logic [1:0]  left;
  } grp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jhash_packer_if #(.CNT_W(CNT_W)) bus ();
  jhash_packer #(.HOLDOFF(HOLDOFF), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  grp_t exp_q[$];
  int   checks    = 0;
  int   passes    = 0;
  int   ack_delay = -1;
  int   bad_qual  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] stored(input logic [31:0] w);
`ifdef JHASH_PACK_SWAP_EN
    return {<<8{w}};
`else
    return w;
`endif
  endfunction

  // Reference: a message is cut into chunks of three; the last chunk is final and zero-padded.
  task automatic model_push(input wq_t words);
    int   n;
    grp_t e;
    logic [31:0] t [3];
    n = words.size();
    if (n == 0) begin
      e = '{d0: 32'd0, d1: 32'd0, d2: 32'd0, done: 1'b1, left: 2'd0};
      exp_q.push_back(e);
    end else begin
      for (int g = 0; g * 3 < n; g++) begin
        for (int k = 0; k < 3; k++) t[k] = (g * 3 + k < n) ? stored(words[g * 3 + k]) : 32'd0;
        e.d0   = t[0];
        e.d1   = t[1];
        e.d2   = t[2];
        e.done = (g * 3 + 3 >= n);
        e.left = e.done ? 2'(n - g * 3) : 2'd0;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic send_word(input logic [31:0] w, input logic last);
    int n;
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    n = 0;
    while (!bus.in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("accept_timeout", 64'(n), 64'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_msg(input wq_t words);
    int n;
    int sz;
    sz = words.size();
    model_push(words);
    if (sz == 0) begin
      bus.in_empty = 1'b1;
      @(negedge clk);
      bus.in_empty = 1'b0;
    end else begin
      for (int i = 0; i < sz; i++) send_word(words[i], i == sz - 1);
    end
    n = 0;
    while (!bus.pack_done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("pack_done_seen", 64'(bus.pack_done), 64'd1);
    chk("word_cnt", 64'(bus.word_cnt), 64'((sz > 65535) ? 65535 : sz));
    chk("end_ready_low", 64'(bus.in_ready), 64'd0);
    chk("end_valid_low", 64'(bus.stream_valid), 64'd0);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    do_reset();
  endtask

  // Monitor: each rising stream_valid must match the head of the expected queue.
  initial begin
    logic prev_v;
    logic unstable;
    grp_t cap, e;
    prev_v   = 1'b0;
    unstable = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v   = 1'b0;
        unstable = 1'b0;
        continue;
      end
      if ((bus.stream_done && !bus.stream_valid) || (!bus.stream_done && bus.stream_left != 2'd0))
        bad_qual++;
      if (bus.stream_valid && !prev_v) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_group", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("group_d0", 64'(bus.stream_data0), 64'(e.d0));
          chk("group_d1", 64'(bus.stream_data1), 64'(e.d1));
          chk("group_d2", 64'(bus.stream_data2), 64'(e.d2));
          chk("group_done", 64'(bus.stream_done), 64'(e.done));
          chk("group_left", 64'(bus.stream_left), 64'(e.left));
        end
        cap = '{d0: bus.stream_data0, d1: bus.stream_data1, d2: bus.stream_data2,
                done: bus.stream_done, left: bus.stream_left};
      end else if (bus.stream_valid && prev_v) begin
        if (bus.stream_data0 !== cap.d0 || bus.stream_data1 !== cap.d1 ||
            bus.stream_data2 !== cap.d2 || bus.stream_done !== cap.done ||
            bus.stream_left !== cap.left)
          unstable = 1'b1;
      end else if (!bus.stream_valid && prev_v) begin
        chk("group_stable", 64'(unstable), 64'd0);
        unstable = 1'b0;
      end
      prev_v = bus.stream_valid;
    end
  end

  // Core model: acks non-final groups, measures the hold-off, answers the final group.
  initial begin
    int d;
    int gap;
    int n;
    bus.stream_ack = 1'b0;
    bus.hash_done  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) continue;
      if (bus.stream_valid && !bus.stream_done) begin
        d = (ack_delay >= 0) ? ack_delay : $urandom_range(0, 4);
        chk("send_ready_low", 64'(bus.in_ready), 64'd0);
        for (int i = 0; i < d && !rst; i++) @(negedge clk);
        if (rst) continue;
        chk("send_still_valid", 64'(bus.stream_valid), 64'd1);
        bus.stream_ack = 1'b1;
        @(negedge clk);
        bus.stream_ack = 1'b0;
        gap = 0;
        while (!bus.in_ready && !rst && gap < 20) begin
          if (bus.stream_valid || bus.stream_done) bad_qual++;
          @(negedge clk);
          gap++;
        end
        if (!rst) chk("holdoff_gap", 64'(gap), 64'(HOLDOFF));
      end else if (bus.stream_valid && bus.stream_done) begin
        d = $urandom_range(0, 4);
        if ($urandom_range(0, 1) == 1) begin
          bus.stream_ack = 1'b1;
          @(negedge clk);
          bus.stream_ack = 1'b0;
        end
        repeat (d) @(negedge clk);
        bus.hash_done = 1'b1;
        @(negedge clk);
        bus.hash_done = 1'b0;
        chk("pack_done_latency", 64'(bus.pack_done), 64'd1);
        chk("end_stream_valid", 64'(bus.stream_valid), 64'd0);
        n = 0;
        while (!rst && n < 5000) begin
          @(negedge clk);
          n++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wq_t w;
    int  n;
    logic [31:0] a, b, c;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_empty = 1'b0;
    #1;
    chk("rst_valid", 64'(bus.stream_valid), 64'd0);
    chk("rst_done", 64'(bus.stream_done), 64'd0);
    chk("rst_left", 64'(bus.stream_left), 64'd0);
    chk("rst_data", 64'({bus.stream_data0, bus.stream_data1} | 64'(bus.stream_data2)), 64'd0);
    chk("rst_word_cnt", 64'(bus.word_cnt), 64'd0);
    chk("rst_pack_done", 64'(bus.pack_done), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    w = '{32'h11111111, 32'h22222222, 32'h33333333};
    run_msg(w);
    w = '{32'd1, 32'd2, 32'd3, 32'd4};
    run_msg(w);
    w = {};
    run_msg(w);
    ack_delay = 5;
    w = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4};
    run_msg(w);
    ack_delay = -1;
    w = '{32'hAABBCCDD};
    run_msg(w);

    // Reset while holding off after the first group of an unfinished message.
    a = $urandom; b = $urandom; c = $urandom;
    exp_q.push_back('{d0: stored(a), d1: stored(b), d2: stored(c), done: 1'b0, left: 2'd0});
    send_word(a, 1'b0);
    send_word(b, 1'b0);
    send_word(c, 1'b0);
    n = 0;
    while (!bus.stream_valid && n < 100) begin @(negedge clk); n++; end
    while (bus.stream_valid && n < 200) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    chk("hold_word_cnt", 64'(bus.word_cnt), 64'd3);
    chk("hold_ready_low", 64'(bus.in_ready), 64'd0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(bus.stream_valid), 64'd0);
    chk("midrst_word_cnt", 64'(bus.word_cnt), 64'd0);
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("midrst_pack_done", 64'(bus.pack_done), 64'd0);
    @(negedge clk);
    exp_q.delete();
    rst = 1'b0;
    w = '{32'h5EED0001, 32'h5EED0002};
    run_msg(w);

    for (int m = 0; m < 20; m++) begin
      w = {};
      n = $urandom_range(0, 10);
      for (int i = 0; i < n; i++) w.push_back($urandom);
      run_msg(w);
    end

    chk("output_qualifiers", 64'(bad_qual), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
